// File: rtl/match_timer_if.sv
// match_timer_if: bundles the match-clock controls and displays between the game side and the timer.
// Ports: btn_up, btn_down, btn_start, btn_pause, stop (game -> timer); max_time, time_left, state, time_up (timer -> game).
// master = game/button side, slave = match_timer.
interface match_timer_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_start;
  logic       btn_pause;
  logic       stop;
  logic [7:0] max_time;
  logic [7:0] time_left;
  logic [1:0] state;
  logic       time_up;

  modport master (
    output btn_up, btn_down, btn_start, btn_pause, stop,
    input  max_time, time_left, state, time_up
  );

  modport slave (
    input  btn_up, btn_down, btn_start, btn_pause, stop,
    output max_time, time_left, state, time_up
  );
endinterface

// File: rtl/match_timer.sv
// match_timer: pong match clock -- length select in SET, once-per-second countdown in RUN/PAUSE, expiry pulse into DONE.
// Latency: a button level rising before edge n acts at edge n+1 (input register + edge detect); stop acts on the next edge.
// Backpressure: none; buttons are sampled every cycle and stop overrides every button.
// Ports: clk, reset (async, active-high); bus (match_timer_if.slave):
//   in  btn_up, btn_down, btn_start, btn_pause, stop
//   out max_time[7:0], time_left[7:0], state[1:0] (SET=0 RUN=1 PAUSE=2 DONE=3), time_up (one-cycle pulse)
// Build option: define MATCH_TIMER_WRAP_EN to make up/down wrap between MIN_TIME and MAX_TIME instead of saturating.
module match_timer #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int STEP         = 15,
  parameter int MIN_TIME     = 30,
  parameter int MAX_TIME     = 240,
  parameter int DEFAULT_TIME = 60
) (
  input  logic         clk,
  input  logic         reset,
  match_timer_if.slave bus
);

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  // Length arithmetic is done at 9 bits so MAX_TIME + STEP never wraps.
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MIN9  = 9'(MIN_TIME);
  localparam logic [8:0] MAX9  = 9'(MAX_TIME);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [7:0] MIN8  = 8'(MIN_TIME);
  localparam logic [7:0] MAX8  = 8'(MAX_TIME);
  localparam logic [7:0] DEF8  = 8'(DEFAULT_TIME);

  // Button bit order in the sample/previous registers.
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_START = 2;
  localparam int B_PAUSE = 3;

  logic [3:0]    btn_s;
  logic [3:0]    btn_p;
  logic [3:0]    press;
  logic          up_press;
  logic          down_press;
  logic          start_press;
  logic          pause_press;

  logic [1:0]    state_q, state_d;
  logic [7:0]    max_q, max_d;
  logic [7:0]    left_q, left_d;
  logic          up_q, up_d;
  logic [PW-1:0] presc_q, presc_d;

  logic [8:0]    sum9;
  logic          down_ok;
  logic [7:0]    max_step;
  logic          tick;

  // Both registers reset to 1 so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s <= '1;
      btn_p <= '1;
    end else begin
      btn_s <= {bus.btn_pause, bus.btn_start, bus.btn_down, bus.btn_up};
      btn_p <= btn_s;
    end
  end

  assign press       = btn_s & ~btn_p;
  // Up and down together cancel out.
  assign up_press    = press[B_UP] & ~press[B_DOWN];
  assign down_press  = press[B_DOWN] & ~press[B_UP];
  assign start_press = press[B_START];
  assign pause_press = press[B_PAUSE];

  // Candidate match length after this cycle's up/down press.
  always_comb begin
    sum9     = {1'b0, max_q} + STEP9;
    down_ok  = ({1'b0, max_q} >= (MIN9 + STEP9));
    max_step = max_q;
`ifdef MATCH_TIMER_WRAP_EN
    if (up_press) begin
      if (max_q == MAX8)     max_step = MIN8;
      else if (sum9 > MAX9)  max_step = MAX8;
      else                   max_step = sum9[7:0];
    end else if (down_press) begin
      if (max_q == MIN8)     max_step = MAX8;
      else if (!down_ok)     max_step = MIN8;
      else                   max_step = max_q - STEP8;
    end
`else
    if (up_press) begin
      max_step = (sum9 > MAX9) ? MAX8 : sum9[7:0];
    end else if (down_press) begin
      max_step = down_ok ? (max_q - STEP8) : MIN8;
    end
`endif
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    left_d  = left_q;
    up_d    = 1'b0;
    presc_d = presc_q;
    if (bus.stop) begin
      state_d = ST_SET;
      left_d  = max_q;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_SET: begin
          max_d  = max_step;
          left_d = max_step;
          if (start_press) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) left_d = left_q - 8'd1;
          // Expiry wins over a pause press on the same cycle.
          if (tick && (left_q <= 8'd1)) begin
            left_d  = '0;
            state_d = ST_DONE;
            up_d    = 1'b1;
          end else if (pause_press) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // Prescaler holds, so the partial second resumes where it stopped.
          if (pause_press || start_press) state_d = ST_RUN;
        end
        ST_DONE: begin
          left_d = '0;
          if (start_press) begin
            state_d = ST_SET;
            left_d  = max_q;
          end
        end
        default: begin
          state_d = ST_SET;
          left_d  = max_q;
          presc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SET;
      max_q   <= DEF8;
      left_q  <= DEF8;
      up_q    <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      left_q  <= left_d;
      up_q    <= up_d;
      presc_q <= presc_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.max_time  = max_q;
  assign bus.time_left = left_q;
  assign bus.time_up   = up_q;

endmodule

// File: tb/tb_match_timer.sv
// tb_match_timer: directed bench for match_timer with CLK_HZ=10 and default length limits.
// Expected snapshots are queued when a press is driven and popped once the press has taken effect.
`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      errors++; \
      $error("FAIL %s: got %0d expected %0d", TAG, OBS, EXP); \
    end \
  end

module tb_match_timer;
  localparam int TB_HZ = 10;
  localparam int NONE  = 100000;
  localparam logic [1:0] S_SET   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  match_timer_if bus_if();

  match_timer #(.CLK_HZ(TB_HZ)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] mx;
    logic [7:0] lf;
  } snap_t;

  snap_t      exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl_max;
  int         ue;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input bit u, input bit d, input bit s, input bit p);
    bus_if.btn_up    = u;
    bus_if.btn_down  = d;
    bus_if.btn_start = s;
    bus_if.btn_pause = p;
  endtask

  // One-cycle button pulse; returns just after the edge where it takes effect.
  task automatic press(input bit u, input bit d, input bit s, input bit p);
    set_btns(u, d, s, p);
    step();
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic sb_push(input logic [1:0] st, input logic [7:0] mx, input logic [7:0] lf, input string tag);
    snap_t s;
    s.st = st;
    s.mx = mx;
    s.lf = lf;
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check();
    snap_t e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      `CHK({t, "/state"},     bus_if.state,     e.st)
      `CHK({t, "/max_time"},  bus_if.max_time,  e.mx)
      `CHK({t, "/time_left"}, bus_if.time_left, e.lf)
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] cur, input bit up, input bit dn);
    int v;
    v = int'(cur);
    if (up && !dn) begin
`ifdef MATCH_TIMER_WRAP_EN
      if (v == 240)          v = 30;
      else if (v + 15 > 240) v = 240;
      else                   v = v + 15;
`else
      v = (v + 15 > 240) ? 240 : v + 15;
`endif
    end else if (dn && !up) begin
`ifdef MATCH_TIMER_WRAP_EN
      if (v == 30)           v = 240;
      else if (v - 15 < 30)  v = 30;
      else                   v = v - 15;
`else
      v = (v - 15 < 30) ? 30 : v - 15;
`endif
    end
    return 8'(v);
  endfunction

  task automatic do_len_press(input bit u, input bit d, input string tag);
    mdl_max = model_next(mdl_max, u, d);
    sb_push(S_SET, mdl_max, mdl_max, tag);
    press(u, d, 1'b0, 1'b0);
    sb_check();
  endtask

  // Cycle-by-cycle model of a match already in RUN. Pause pulses are driven right
  // after edges pa/ra/la and take effect two edges later.
  task automatic run_match(input logic [7:0] start_left, input int pa, input int ra, input int la,
                           input int limit, output int up_edge);
    logic [1:0] es, ps;
    logic [7:0] el;
    logic       eu;
    int         run_cnt;
    int         done_seen;
    es = S_RUN;
    el = start_left;
    run_cnt = 0;
    up_edge = -1;
    done_seen = 0;
    for (int c = 0; c < limit; c++) begin
      bus_if.btn_pause = (c == pa) || (c == ra) || (c == la);
      step();
      ps = es;
      eu = 1'b0;
      if (ps == S_RUN) begin
        run_cnt++;
        if (run_cnt % TB_HZ == 0) begin
          el = el - 8'd1;
          if (el == 8'd0) begin
            es = S_DONE;
            eu = 1'b1;
            up_edge = c + 1;
          end
        end
      end
      if ((c + 1 == pa + 2) || (c + 1 == ra + 2) || (c + 1 == la + 2)) begin
        if (ps == S_RUN && !eu) es = S_PAUSE;
        else if (ps == S_PAUSE) es = S_RUN;
      end
      `CHK("run_state",   bus_if.state,     es)
      `CHK("run_left",    bus_if.time_left, el)
      `CHK("run_time_up", bus_if.time_up,   eu)
      if (es == S_DONE) done_seen++;
      if (done_seen == 3) break;
    end
    bus_if.btn_pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with btn_up held: no press may be seen.
    reset = 1'b1;
    bus_if.stop = 1'b0;
    set_btns(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    `CHK("rst_state",   bus_if.state,     S_SET)
    `CHK("rst_max",     bus_if.max_time,  8'd60)
    `CHK("rst_left",    bus_if.time_left, 8'd60)
    `CHK("rst_time_up", bus_if.time_up,   1'b0)
    reset = 1'b0;
    step();
    step();
    step();
    `CHK("held_after_rst", bus_if.max_time, 8'd60)
    bus_if.btn_up = 1'b0;
    step();
    step();
    `CHK("release", bus_if.max_time, 8'd60)
    mdl_max = 8'd60;
    do_len_press(1'b1, 1'b0, "up_once");

    // Saturate upwards, then simultaneous up/down, then one more up at the top.
    for (int i = 0; i < 20; i++) do_len_press(1'b1, 1'b0, "up_sat");
    `CHK("sat_top", bus_if.max_time, 8'd240)
    do_len_press(1'b1, 1'b1, "up_down_same");
    do_len_press(1'b1, 1'b0, "up_at_top");

    // Down to the floor, one press past it, and back to the floor.
    for (int i = 0; i < 20 && mdl_max != 8'd30; i++) do_len_press(1'b0, 1'b1, "down");
    do_len_press(1'b0, 1'b1, "down_at_floor");
    for (int i = 0; i < 20 && mdl_max != 8'd30; i++) do_len_press(1'b0, 1'b1, "down2");
    `CHK("floor", bus_if.max_time, 8'd30)

    // Full 30 s match without pauses.
    sb_push(S_RUN, 8'd30, 8'd30, "start1");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check();
    run_match(8'd30, NONE, NONE, NONE, 400, ue);
    `CHK("time_up_edge1", ue, 300)
    sb_push(S_SET, 8'd30, 8'd30, "start_in_done");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check();

    // Pause at prescaler 4 for 37 cycles, then a pause press landing on the final tick.
    sb_push(S_RUN, 8'd30, 8'd30, "start2");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check();
    run_match(8'd30, 12, 49, 335, 500, ue);
    `CHK("time_up_edge2", ue, 337)
    sb_push(S_SET, 8'd30, 8'd30, "start_in_done2");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check();

    // Reset mid-match takes effect without a clock edge.
    sb_push(S_RUN, 8'd30, 8'd30, "start3");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check();
    for (int i = 0; i < 25; i++) step();
    reset = 1'b1;
    #1;
    `CHK("async_rst_state", bus_if.state,     S_SET)
    `CHK("async_rst_max",   bus_if.max_time,  8'd60)
    `CHK("async_rst_left",  bus_if.time_left, 8'd60)
    `CHK("async_rst_up",    bus_if.time_up,   1'b0)
    step();
    reset = 1'b0;
    step();
    mdl_max = 8'd60;

    // stop while paused with time_left = 12, max_time = 45.
    do_len_press(1'b0, 1'b1, "to_45");
    sb_push(S_RUN, 8'd45, 8'd45, "start4");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    sb_check();
    for (int i = 0; i < 400 && bus_if.time_left != 8'd12; i++) step();
    `CHK("reach_12", bus_if.time_left, 8'd12)
    sb_push(S_PAUSE, 8'd45, 8'd12, "pause_at_12");
    press(1'b0, 1'b0, 1'b0, 1'b1);
    sb_check();
    bus_if.stop = 1'b1;
    step();
    `CHK("stop_state", bus_if.state,     S_SET)
    `CHK("stop_left",  bus_if.time_left, 8'd45)
    `CHK("stop_max",   bus_if.max_time,  8'd45)
    bus_if.stop = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
